// File: rtl/box_drawer.sv
// Erase/redraw engine feeding box pixels to the VGA adapter, one pixel per clock.
// Optional BOX_DRAWER_FLY_COLOUR_EN selects FLY_COLOUR for the box while flying.
module box_drawer #(
  parameter int unsigned BOX_X      = 20,
  parameter int unsigned BOX_SIZE   = 4,
  parameter int unsigned Y_MAX      = 119,
  parameter logic [2:0]  BG_COLOUR  = 3'b000,
  parameter logic [2:0]  BOX_COLOUR = 3'b110,
  parameter logic [2:0]  FLY_COLOUR = 3'b011
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [6:0] y_coordinate,
  input  logic       flying,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(BOX_SIZE - 1);
  localparam logic [7:0] X0   = 8'(BOX_X);
  localparam logic [7:0] YLIM = 8'(Y_MAX);

  state_t     r_state;
  logic [3:0] r_cx, r_cy;
  logic [6:0] r_old_y, r_new_y;
  logic       r_drawn_valid;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot, r_busy, r_frame_done;

  state_t     w_nx_state;
  logic [3:0] w_nx_cx, w_nx_cy;
  logic [6:0] w_nx_base;
  logic [2:0] w_nx_colour;
  logic       w_nx_walk;
  logic       w_last;
  logic [2:0] w_draw_colour;
  logic [7:0] w_row_wide;

`ifdef BOX_DRAWER_FLY_COLOUR_EN
  logic r_fly;
  always_comb begin
    // Entering DRAW straight from IDLE must use the value being latched this edge.
    if (r_state == S_IDLE) w_draw_colour = flying ? FLY_COLOUR : BOX_COLOUR;
    else                   w_draw_colour = r_fly  ? FLY_COLOUR : BOX_COLOUR;
  end
`else
  logic w_unused_flying;
  assign w_unused_flying = flying;
  assign w_draw_colour   = BOX_COLOUR;
`endif

  assign w_last = (r_cx == LAST) && (r_cy == LAST);

  // Next-pixel selection: outputs are registered alongside the state, so the
  // address computed here is the one presented during the following cycle.
  always_comb begin
    w_nx_state  = r_state;
    w_nx_cx     = r_cx;
    w_nx_cy     = r_cy;
    w_nx_base   = r_new_y;
    w_nx_colour = w_draw_colour;
    w_nx_walk   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (game_tick) begin
          w_nx_cx   = '0;
          w_nx_cy   = '0;
          w_nx_walk = 1'b1;
          if (r_drawn_valid) begin
            w_nx_state  = S_ERASE;
            w_nx_base   = r_old_y;
            w_nx_colour = BG_COLOUR;
          end else begin
            w_nx_state = S_DRAW;
            w_nx_base  = y_coordinate;
          end
        end
      end
      S_ERASE: begin
        w_nx_walk = 1'b1;
        if (w_last) begin
          w_nx_state = S_DRAW;
          w_nx_cx    = '0;
          w_nx_cy    = '0;
        end else begin
          w_nx_base   = r_old_y;
          w_nx_colour = BG_COLOUR;
          if (r_cx == LAST) begin
            w_nx_cx = '0;
            w_nx_cy = r_cy + 4'd1;
          end else begin
            w_nx_cx = r_cx + 4'd1;
          end
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_nx_state = S_DONE;
          w_nx_cx    = '0;
          w_nx_cy    = '0;
        end else begin
          w_nx_walk = 1'b1;
          if (r_cx == LAST) begin
            w_nx_cx = '0;
            w_nx_cy = r_cy + 4'd1;
          end else begin
            w_nx_cx = r_cx + 4'd1;
          end
        end
      end
      S_DONE: begin
        w_nx_state = S_IDLE;
        w_nx_cx    = '0;
        w_nx_cy    = '0;
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  // 8-bit row so that rows wrapping past 127 are still clipped.
  assign w_row_wide = {1'b0, w_nx_base} + {4'b0000, w_nx_cy};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cx          <= '0;
      r_cy          <= '0;
      r_old_y       <= '0;
      r_new_y       <= '0;
      r_drawn_valid <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_colour      <= '0;
      r_plot        <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
`ifdef BOX_DRAWER_FLY_COLOUR_EN
      r_fly         <= 1'b0;
`endif
    end else begin
      r_state      <= w_nx_state;
      r_cx         <= w_nx_cx;
      r_cy         <= w_nx_cy;
      r_busy       <= (w_nx_state != S_IDLE);
      r_frame_done <= (w_nx_state == S_DONE);
      if (r_state == S_IDLE && game_tick) begin
        r_new_y <= y_coordinate;
`ifdef BOX_DRAWER_FLY_COLOUR_EN
        r_fly   <= flying;
`endif
      end
      if (r_state == S_DONE) begin
        r_old_y       <= r_new_y;
        r_drawn_valid <= 1'b1;
      end
      if (w_nx_walk) begin
        r_x      <= X0 + {4'b0000, w_nx_cx};
        r_y      <= w_nx_base + {3'b000, w_nx_cy};
        r_colour <= w_nx_colour;
        r_plot   <= (w_row_wide <= YLIM);
      end else begin
        r_plot   <= 1'b0;
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign colour     = r_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_box_drawer.sv
// Directed bench for box_drawer: per-pixel checks of erase/draw walks, clipping and timing.
module tb_box_drawer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       game_tick;
  logic [6:0] y_coordinate;
  logic       flying;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BOX_DRAWER_FLY_COLOUR_EN
  localparam logic [2:0] EXP_FLY = 3'b011;
`else
  localparam logic [2:0] EXP_FLY = 3'b110;
`endif

  box_drawer dut (
    .clock(clock), .resetn(resetn), .game_tick(game_tick),
    .y_coordinate(y_coordinate), .flying(flying),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse game_tick for one edge; on return the first pixel is on the outputs.
  task automatic fire(input int yc, input logic fl);
    y_coordinate = 7'(yc);
    flying       = fl;
    game_tick    = 1'b1;
    step();
    game_tick    = 1'b0;
  endtask

  // Checks 16 consecutive pixels of one 4x4 walk, advancing one cycle after each.
  task automatic walk(input string nm, input int base, input logic [2:0] col);
    for (int i = 0; i < 16; i++) begin
      int         row;
      logic [7:0] ex;
      logic [6:0] ey;
      logic       ep;
      row = base + i / 4;
      ex  = 8'(20 + i % 4);
      ey  = 7'(row);
      ep  = (row <= 119);
      n_checks++;
      if (x !== ex || y !== ey || plot !== ep || busy !== 1'b1 || frame_done !== 1'b0 ||
          (ep && colour !== col)) begin
        n_fail++;
        $display("FAIL %s pix%0d: x=%0d y=%0d col=%b plot=%b busy=%b fd=%b, want x=%0d y=%0d col=%b plot=%b busy=1 fd=0",
                 nm, i, x, y, colour, plot, busy, frame_done, ex, ey, col, ep);
      end
      step();
    end
  endtask

  task automatic finish_frame(input string nm);
    n_checks++;
    if (frame_done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: fd=%b plot=%b busy=%b, want fd=1 plot=0 busy=1", nm, frame_done, plot, busy);
    end
    step();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: fd=%b busy=%b plot=%b, want 0 0 0", nm, frame_done, busy, plot);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; game_tick = 1'b0; y_coordinate = 7'd0; flying = 1'b0;
    step(); step();
    n_checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: x=%0d y=%0d col=%b plot=%b busy=%b fd=%b, want all 0", x, y, colour, plot, busy, frame_done);
    end
    resetn = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b plot=%b, want 0 0", busy, plot);
    end
  endtask

  task automatic test_first_frame();
    fire(60, 1'b0);
    walk("first_draw", 60, 3'b110);
    finish_frame("first");
    n_checks++;
    if (x !== 8'd23 || y !== 7'd63 || colour !== 3'b110) begin
      n_fail++;
      $display("FAIL first_hold: x=%0d y=%0d col=%b, want 23 63 110", x, y, colour);
    end
  endtask

  task automatic test_erase_frame();
    fire(58, 1'b0);
    walk("erase60", 60, 3'b000);
    walk("draw58", 58, 3'b110);
    finish_frame("second");
  endtask

  task automatic test_clip();
    fire(118, 1'b0);
    walk("erase58", 58, 3'b000);
    walk("draw118", 118, 3'b110);
    finish_frame("clip118");
    fire(126, 1'b0);
    walk("erase118", 118, 3'b000);
    walk("draw126", 126, 3'b110);
    finish_frame("clip126");
  endtask

  task automatic test_busy_drop();
    int k;
    int seen;
    fire(40, 1'b0);
    k = 1;
    repeat (4) begin step(); k++; end
    y_coordinate = 7'd10;
    game_tick = 1'b1;
    step(); k++;
    game_tick = 1'b0;
    while (frame_done !== 1'b1 && k < 60) begin step(); k++; end
    n_checks++;
    if (k !== 33) begin
      n_fail++;
      $display("FAIL drop_timing: frame_done at cycle %0d, want 33", k);
    end
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL drop_extra: %0d busy/done cycles after frame, want 0", seen);
    end
    n_checks++;
    if (x !== 8'd23 || y !== 7'd43) begin
      n_fail++;
      $display("FAIL drop_latched: x=%0d y=%0d, want 23 43", x, y);
    end
  endtask

  task automatic test_back_to_back();
    fire(50, 1'b0);
    walk("erase40", 40, 3'b000);
    walk("draw50", 50, 3'b110);
    finish_frame("b2b");
  endtask

  task automatic test_reset_mid();
    fire(20, 1'b0);
    walk("erase50_abort", 50, 3'b000);
    repeat (3) step();
    resetn = 1'b0;
    step();
    n_checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin
      n_fail++;
      $display("FAIL mid_reset: plot=%b busy=%b fd=%b x=%0d y=%0d, want 0 0 0 0 0", plot, busy, frame_done, x, y);
    end
    resetn = 1'b1;
    step(); step();
    fire(30, 1'b0);
    walk("redraw30", 30, 3'b110);
    finish_frame("after_reset");
  endtask

  task automatic test_flying();
    fire(70, 1'b1);
    flying = 1'b0;
    walk("erase30", 30, 3'b000);
    walk("fly70", 70, EXP_FLY);
    finish_frame("fly");
    fire(80, 1'b0);
    walk("erase70", 70, 3'b000);
    walk("land80", 80, 3'b110);
    finish_frame("land");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_erase_frame();
    test_clip();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid();
    test_flying();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
